// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong match controller.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    SRV_ANY = 2'd0,
    SRV_P1  = 2'd1,
    SRV_P2  = 2'd2
  } server_sel_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int BTN_P2  = 0;
  localparam int BTN_NEW = 1;
  localparam int BTN_P1  = 2;

  function automatic logic [2:0] score_inc(input logic [2:0] score, input logic [2:0] limit);
    if (score < limit) begin
      score_inc = score + 3'd1;
    end else begin
      score_inc = score;
    end
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Link between the match controller and the ball/paddle physics block.
interface pong_game_ctrl_if;
  logic frame_tick;
  logic physics_en;
  logic ball_reset;
  logic serve_dir;
  logic miss_left;
  logic miss_right;

  modport master (
    output frame_tick, physics_en, ball_reset, serve_dir,
    input  miss_left, miss_right
  );

  modport slave (
    input  frame_tick, physics_en, ball_reset, serve_dir,
    output miss_left, miss_right
  );
endinterface

// File: rtl/pong_button_sync.sv
// Two-flop synchronizer plus falling-edge pulse for active-low push buttons.
module pong_button_sync #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pin_n,
  output logic [N-1:0] press
);

  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] arm_q, arm_d;
  logic [1:0]   valid_q, valid_d;

  // A bit only arms once a genuine released level has passed the synchronizer,
  // so a button held down across reset release never produces a press.
  always_comb begin
    sync1_d = pin_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    valid_d = {valid_q[0], 1'b1};
    arm_d   = arm_q | (sync2_q & {N{valid_q[1]}});
  end

  assign press = arm_q & prev_q & ~sync2_q;

  // Synchronizer, edge-detect and arming registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      arm_q   <= '0;
      valid_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: frame tick divider, scores and the serve/play/point FSM.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_GUARD = 30,
  parameter int POINT_PAUSE = 90,
  parameter int WIN_SCORE   = 7
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [2:0]        PushButton,
  pong_game_ctrl_if.master  phy,
  output logic [2:0]        player_1_score,
  output logic [2:0]        player_2_score,
  output logic [2:0]        game_state,
  output logic [1:0]        winner
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int GUARD_W = (SERVE_GUARD < 1) ? 1 : $clog2(SERVE_GUARD + 1);
  localparam int PAUSE_W = (POINT_PAUSE < 1) ? 1 : $clog2(POINT_PAUSE + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(SERVE_GUARD);
  localparam logic [PAUSE_W-1:0] PAUSE_MAX = PAUSE_W'(POINT_PAUSE);
  localparam logic [2:0]         WIN_S     = 3'(WIN_SCORE);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic [2:0]         p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         win_q, win_d;
  logic               dir_q, dir_d;
  game_state_t        state_q, state_d;
  server_sel_t        srv_q, srv_d;
  logic               tick_s, p1_ok_s, p2_ok_s;
  logic [2:0]         press_s;

  pong_button_sync #(.N(3)) u_btn (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .pin_n (PushButton),
    .press (press_s)
  );

  // Free-running frame divider, independent of the match state.
  always_comb begin
    tick_s = (div_q == DIV_LAST);
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Match FSM next-state; a new-game press overrides every state.
  always_comb begin
    state_d = state_q;
    srv_d   = srv_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    guard_d = guard_q;
    pause_d = pause_q;
    p1_ok_s = press_s[BTN_P1] && (srv_q != SRV_P2);
    p2_ok_s = press_s[BTN_P2] && (srv_q != SRV_P1);
    if (press_s[BTN_NEW]) begin
      state_d = ST_IDLE;
      p1_d    = 3'd0;
      p2_d    = 3'd0;
      win_d   = WIN_NONE;
      srv_d   = SRV_ANY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_s[BTN_P1] || press_s[BTN_P2]) begin
            state_d = ST_SERVE_WAIT;
            guard_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SERVE_WAIT: begin
          if (tick_s && (guard_q != GUARD_MAX)) begin
            guard_d = guard_q + GUARD_W'(1);
          end else begin
            guard_d = guard_q;
          end
          if ((guard_q == GUARD_MAX) && p1_ok_s) begin
            state_d = ST_PLAY;
            dir_d   = 1'b0;
          end else if ((guard_q == GUARD_MAX) && p2_ok_s) begin
            state_d = ST_PLAY;
            dir_d   = 1'b1;
          end else begin
            state_d = ST_SERVE_WAIT;
          end
        end
        ST_PLAY: begin
          if (phy.miss_right && !phy.miss_left) begin
            p1_d    = score_inc(p1_q, WIN_S);
            srv_d   = SRV_P2;
            state_d = ST_POINT;
            pause_d = '0;
          end else if (phy.miss_left && !phy.miss_right) begin
            p2_d    = score_inc(p2_q, WIN_S);
            srv_d   = SRV_P1;
            state_d = ST_POINT;
            pause_d = '0;
          end else if (phy.miss_left && phy.miss_right) begin
            state_d = ST_POINT;
            pause_d = '0;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_POINT: begin
          if (pause_q == PAUSE_MAX) begin
            if (p1_q == WIN_S) begin
              state_d = ST_GAME_OVER;
              win_d   = WIN_P1;
            end else if (p2_q == WIN_S) begin
              state_d = ST_GAME_OVER;
              win_d   = WIN_P2;
            end else begin
              state_d = ST_SERVE_WAIT;
              guard_d = '0;
            end
          end else if (tick_s) begin
            pause_d = pause_q + PAUSE_W'(1);
          end else begin
            pause_d = pause_q;
          end
        end
        ST_GAME_OVER: state_d = ST_GAME_OVER;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // State, score and counter registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      guard_q <= '0;
      pause_q <= '0;
      p1_q    <= 3'd0;
      p2_q    <= 3'd0;
      win_q   <= WIN_NONE;
      dir_q   <= 1'b0;
      state_q <= ST_IDLE;
      srv_q   <= SRV_ANY;
    end else begin
      div_q   <= div_d;
      guard_q <= guard_d;
      pause_q <= pause_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      srv_q   <= srv_d;
    end
  end

  assign phy.frame_tick  = tick_s;
  assign phy.physics_en  = (state_q == ST_PLAY);
  assign phy.ball_reset  = (state_q != ST_PLAY);
  assign phy.serve_dir   = dir_q;
  assign player_1_score  = p1_q;
  assign player_2_score  = p2_q;
  assign game_state      = state_q;
  assign winner          = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a cycle-level rules model checked every cycle.
module tb_pong_game_ctrl;

  localparam int TD = 4;
  localparam int SG = 2;
  localparam int PP = 3;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [2:0] p1s, p2s, gst;
  logic [1:0] win;
  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;

  pong_game_ctrl_if phy ();

  pong_game_ctrl #(.TICK_DIV(TD), .SERVE_GUARD(SG), .POINT_PAUSE(PP), .WIN_SCORE(WS)) dut (
    .CLOCK_50       (clk),
    .reset_n        (rst_n),
    .PushButton     (btn),
    .phy            (phy),
    .player_1_score (p1s),
    .player_2_score (p2s),
    .game_state     (gst),
    .winner         (win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rules model: states 0..4, server 0 any / 1 P1 / 2 P2, pin history for presses.
  int m_state, m_s1, m_s2, m_win, m_srv, m_dir, m_guard, m_pause, m_div;
  logic [2:0] h1, h2, h3;

  always @(posedge clk or negedge rst_n) begin : model
    int st, s1, s2, wn, srv, dir, grd, pse, dv;
    logic tick;
    logic [2:0] pr;
    if (!rst_n) begin
      m_state <= 0; m_s1 <= 0; m_s2 <= 0; m_win <= 0; m_srv <= 0;
      m_dir <= 0; m_guard <= 0; m_pause <= 0; m_div <= 0;
      h1 <= 3'b000; h2 <= 3'b000; h3 <= 3'b000;
    end else begin
      st = m_state; s1 = m_s1; s2 = m_s2; wn = m_win; srv = m_srv;
      dir = m_dir; grd = m_guard; pse = m_pause;
      tick = (m_div == TD - 1);
      dv = tick ? 0 : m_div + 1;
      // a press is a released sample followed by a pressed sample, seen two edges later
      pr = h3 & ~h2;
      if (pr[1]) begin
        st = 0; s1 = 0; s2 = 0; wn = 0; srv = 0;
      end else if (st == 0) begin
        if (pr[2] || pr[0]) begin st = 1; grd = 0; end
      end else if (st == 1) begin
        if (m_guard == SG && pr[2] && m_srv != 2) begin st = 2; dir = 0; end
        else if (m_guard == SG && pr[0] && m_srv != 1) begin st = 2; dir = 1; end
        if (tick && m_guard < SG) grd = m_guard + 1;
      end else if (st == 2) begin
        if (phy.miss_right && !phy.miss_left) begin s1 = (s1 < WS) ? s1 + 1 : s1; srv = 2; end
        if (phy.miss_left && !phy.miss_right) begin s2 = (s2 < WS) ? s2 + 1 : s2; srv = 1; end
        if (phy.miss_right || phy.miss_left) begin st = 3; pse = 0; end
      end else if (st == 3) begin
        if (m_pause == PP) begin
          if (s1 == WS) begin st = 4; wn = 1; end
          else if (s2 == WS) begin st = 4; wn = 2; end
          else begin st = 1; grd = 0; end
        end else if (tick) begin
          pse = m_pause + 1;
        end
      end
      m_state <= st; m_s1 <= s1; m_s2 <= s2; m_win <= wn; m_srv <= srv;
      m_dir <= dir; m_guard <= grd; m_pause <= pse; m_div <= dv;
      h3 <= h2; h2 <= h1; h1 <= btn;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("frame_tick", int'(phy.frame_tick), (m_div == TD - 1) ? 1 : 0);
    chk("physics_en", int'(phy.physics_en), (m_state == 2) ? 1 : 0);
    chk("ball_reset", int'(phy.ball_reset), (m_state != 2) ? 1 : 0);
    chk("serve_dir", int'(phy.serve_dir), m_dir);
    chk("p1_score", int'(p1s), m_s1);
    chk("p2_score", int'(p2s), m_s2);
    chk("game_state", int'(gst), m_state);
    chk("winner", int'(win), m_win);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int b);
    @(posedge clk); #2;
    btn[b] = 1'b0;
    cyc(2);
    btn[b] = 1'b1;
    cyc(2);
  endtask

  task automatic miss(input logic l, input logic r);
    @(posedge clk); #2;
    phy.miss_left = l; phy.miss_right = r;
    cyc(1);
    phy.miss_left = 1'b0; phy.miss_right = 1'b0;
  endtask

  initial begin
    phy.miss_left = 1'b0;
    phy.miss_right = 1'b0;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("lit_rst_state", int'(gst), 0);
    chk("lit_rst_ball_reset", int'(phy.ball_reset), 1);
    chk("lit_rst_physics_en", int'(phy.physics_en), 0);
    chk("lit_rst_tick", int'(phy.frame_tick), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phy.frame_tick) tick_cnt++;
    end
    chk("lit_tick_count", tick_cnt, 5);
    chk("lit_idle_state", int'(gst), 0);

    // serve guard: early P1 press ignored, later one serves rightward
    press(0);
    chk("lit_sw_entry", int'(gst), 1);
    press(2);
    chk("lit_early_ignored", int'(gst), 1);
    cyc(12);
    press(2);
    chk("lit_play", int'(gst), 2);
    chk("lit_dir0", int'(phy.serve_dir), 0);
    chk("lit_phys_en", int'(phy.physics_en), 1);

    // P1 scores; misses outside PLAY ignored; only P2 may serve next
    miss(1'b0, 1'b1);
    chk("lit_p1_1", int'(p1s), 1);
    chk("lit_point", int'(gst), 3);
    miss(1'b1, 1'b0);
    cyc(16);
    chk("lit_back_sw", int'(gst), 1);
    miss(1'b0, 1'b1);
    chk("lit_p1_still1", int'(p1s), 1);
    chk("lit_p2_still0", int'(p2s), 0);
    cyc(12);
    press(2);
    chk("lit_p1_rejected", int'(gst), 1);
    press(0);
    chk("lit_p2_serve", int'(gst), 2);
    chk("lit_dir1", int'(phy.serve_dir), 1);

    // simultaneous misses: pause without score change
    miss(1'b1, 1'b1);
    chk("lit_both_state", int'(gst), 3);
    chk("lit_both_p1", int'(p1s), 1);
    cyc(16);
    cyc(12);
    press(0);
    chk("lit_play2", int'(gst), 2);

    // P1 wins the match
    miss(1'b0, 1'b1);
    cyc(28);
    press(0);
    miss(1'b0, 1'b1);
    cyc(20);
    chk("lit_game_over", int'(gst), 4);
    chk("lit_winner", int'(win), 1);
    chk("lit_p1_3", int'(p1s), 3);
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    press(2);
    press(0);
    chk("lit_go_hold", int'(gst), 4);
    chk("lit_go_p1", int'(p1s), 3);
    press(1);
    chk("lit_new_state", int'(gst), 0);
    chk("lit_new_p1", int'(p1s), 0);
    chk("lit_new_win", int'(win), 0);

    // async reset mid-PLAY with P1 button held across release
    press(2);
    cyc(12);
    press(2);
    chk("lit_play3", int'(gst), 2);
    btn[2] = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("lit_async_state", int'(gst), 0);
    chk("lit_async_phys", int'(phy.physics_en), 0);
    chk("lit_async_ball", int'(phy.ball_reset), 1);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("lit_no_false_press", int'(gst), 0);
    btn[2] = 1'b1;
    cyc(5);
    press(2);
    chk("lit_press_after_rst", int'(gst), 1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the Pong design. It generates the per-frame update strobe and owns the match state machine (idle, serve, play, point pause, game over). It also holds both scores and tells the ball/paddle physics when to run, when to hold the ball at centre, and which way to serve. It sits between the PushButton pins, the physics block (which reports goal misses) and the BCD score displays.

Parameters:
TICK_DIV, 833333, CLOCK_50 cycles per frame_tick (60 Hz at 50 MHz); must be ≥2
SERVE_GUARD, 30, frame_ticks in SERVE_WAIT before serve presses are accepted
POINT_PAUSE, 90, frame_ticks spent in POINT before leaving
WIN_SCORE, 7, points that end the match; range 1..7

Ports:
CLOCK_50  in  1  system clock; all state on its rising edge
reset_n  in  1  asynchronous, active-low reset
PushButton  in  3  raw active-low buttons: [2] P1 serve, [1] new game, [0] P2 serve
miss_left  in  1  one-cycle pulse from physics: ball passed the left goal (P2 scores)
miss_right  in  1  one-cycle pulse from physics: ball passed the right goal (P1 scores)
frame_tick  out  1  one-cycle strobe every TICK_DIV cycles
physics_en  out  1  high only in PLAY; physics advances on frame_tick & physics_en
ball_reset  out  1  high in every state except PLAY; physics forces ball to centre, velocity 0
serve_dir  out  1  0 = ball launches rightward (P1 served), 1 = leftward; valid on entry to PLAY
player_1_score  out  3  P1 points
player_2_score  out  3  P2 points
game_state  out  3  IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4
winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (reset_n low, async): state IDLE, scores 0, winner 00, serve_dir 0, all counters 0, server_sel=any. Synchronizer flops reset to 1 (released), so releasing reset never produces a false press. Outputs after reset: physics_en 0, ball_reset 1, frame_tick 0.
- Tick divider: free-running 0..TICK_DIV-1. frame_tick is high during the cycle count==TICK_DIV-1. The divider is unaffected by game state.
- Buttons: each bit passes through a 2-FF synchronizer, then a falling-edge detect. A press is a 1-cycle pulse 3 cycles after the pin falls. Holding a button produces exactly one press.
- New-game press (bit 1) has top priority in every state. Next cycle: state IDLE, scores 0, winner 00, server_sel=any.
- IDLE: a P1 or P2 press goes to SERVE_WAIT and clears the guard counter.
- SERVE_WAIT: the guard counter increments on each frame_tick, saturating at SERVE_GUARD. Presses are ignored until the guard equals SERVE_GUARD. After that, a press from an allowed server goes to PLAY:
  - P1 press sets serve_dir=0; P2 press sets serve_dir=1.
  - If server_sel=any and both press in the same cycle, P1 wins.
- PLAY:
  - miss_right alone: P1 score+1, server_sel=P2, go to POINT.
  - miss_left alone: P2 score+1, server_sel=P1, go to POINT.
  - Both in the same cycle: no score change, server_sel unchanged, go to POINT.
  - Misses in any other state are ignored.
- POINT: the pause counter clears on entry and increments on frame_tick. When it reaches POINT_PAUSE:
  - if either score equals WIN_SCORE, go to GAME_OVER and set winner;
  - otherwise go to SERVE_WAIT with the guard cleared.
- GAME_OVER: scores and winner held; only a new-game press leaves.
- Scores never exceed WIN_SCORE and never wrap.
- physics_en, ball_reset and game_state are decoded combinationally from the state register (no extra latency).

Decomposition:
- Package pong_pkg: game_state_t enum with the encodings above; winner codes; server_sel_t (ANY, P1, P2).
- Sub-module pong_button_sync: N-bit 2-FF synchronizer plus falling-edge pulse, async active-low reset to all-ones.
- Tick divider, counters and FSM live in pong_game_ctrl.

Test Plan (TICK_DIV=4, SERVE_GUARD=2, POINT_PAUSE=3, WIN_SCORE=3):
- Reset then idle 20 cycles: frame_tick pulses at cycles 3, 7, 11…; state 0; ball_reset 1; physics_en 0; no presses decoded.
- IDLE, press P2, then press P1 before 2 ticks elapse: state 1. The early P1 press is ignored. A P1 press after the 2nd tick gives state 2, serve_dir 0, physics_en 1.
- In PLAY, pulse miss_right: player_1_score 1, state 3. After 3 frame_ticks: state 1, only a P2 press is accepted, giving serve_dir 1.
- In PLAY, assert miss_left and miss_right together: scores unchanged, state 3. Miss pulses in states 1 and 3 leave scores unchanged.
- Drive P1 to 3 points: after the final pause, state 4 and winner 01. Further misses and serve presses do nothing. A new-game press gives state 0 and scores 0/0 one cycle after the press pulse.
- Assert reset_n low mid-PLAY, between clock edges: outputs return to reset values immediately. Hold PushButton[2] low across the reset release: no press is generated.
